// File: rtl/alarm_clk_debug_ocimem_seq.sv
// JTAG-side sequencer for the on-chip debug monitor RAM: serves JTAG reads/writes
// first and stalls the CPU Avalon debug-memory slave while JTAG work is pending.
module alarm_clk_debug_ocimem_seq #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_rd_done
);

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;
  state_t state, state_nxt;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       rd_q, rd_q2, rd_data;
  logic              sel_a, sel_n, sel_b, strobe_any, a_rd;
  logic [ADDR_W-1:0] load_addr, pend_addr;
  logic              pend_valid, pend_inc, jrd_inc;
  logic              ready_q, crd_ack;
  logic [1:0]        cnt;
  logic              lat_done, issue_j, issue_c, cpu_wr, wait_c;
  logic              unused_jdo;

  assign sel_b      = take_action_ocimem_b;
  assign sel_a      = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_n      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign strobe_any = sel_a | sel_n | sel_b;
  assign a_rd       = sel_a & jdo[26];
  assign load_addr  = jdo[ADDR_W+16:17];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign lat_done = (cnt == 2'(RAM_LAT - 1));
  assign rd_data  = (RAM_LAT == 2) ? rd_q2 : rd_q;

  // Port arbitration: a JTAG write owns the RAM in its strobe cycle, then a queued
  // JTAG read, then the CPU. crd_ack is the cycle the CPU sees its read data.
  always_comb begin
    state_nxt = state;
    issue_j   = 1'b0;
    issue_c   = 1'b0;
    cpu_wr    = 1'b0;
    wait_c    = 1'b1;
    case (state)
      IDLE: begin
        if (pend_valid && !sel_b) begin
          issue_j   = 1'b1;
          state_nxt = JRD;
        end else if (ready_q && !strobe_any && !pend_valid) begin
          if (crd_ack) begin
            wait_c = 1'b0;
          end else if (avs_read) begin
            issue_c   = 1'b1;
            state_nxt = CRD;
          end else begin
            wait_c = 1'b0;
            cpu_wr = avs_write;
          end
        end
      end
      JRD, CRD: begin
        if (lat_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign avs_waitrequest = wait_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      cnt          <= 2'd0;
      jtag_rd_done <= 1'b0;
      crd_ack      <= 1'b0;
      MonDReg      <= 32'd0;
      MonAReg      <= '0;
      avs_readdata <= 32'd0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      pend_inc     <= 1'b0;
      jrd_inc      <= 1'b0;
    end else begin
      state        <= state_nxt;
      ready_q      <= 1'b1;
      jtag_rd_done <= (state == JRD) && lat_done;
      crd_ack      <= (state == CRD) && lat_done;

      if (issue_j || issue_c) cnt <= 2'd0;
      else if (state != IDLE) cnt <= cnt + 2'd1;

      if ((state == JRD) && lat_done) MonDReg <= rd_data;
      if ((state == CRD) && lat_done) avs_readdata <= rd_data;

      // A new read strobe lands in the slot after the issue clears it, so last wins.
      if (issue_j) begin
        pend_valid <= 1'b0;
        jrd_inc    <= pend_inc;
      end
      if (a_rd) begin
        pend_valid <= 1'b1;
        pend_addr  <= load_addr;
        pend_inc   <= 1'b0;
      end else if (sel_n) begin
        pend_valid <= 1'b1;
        pend_addr  <= MonAReg;
        pend_inc   <= 1'b1;
      end

      if (sel_b) MonAReg <= MonAReg + 1'b1;
      else if (sel_a) MonAReg <= load_addr;
      else if ((state == JRD) && lat_done && jrd_inc) MonAReg <= MonAReg + 1'b1;
    end
  end

  // Single-port RAM: at most one of write/read happens per cycle by construction.
  always_ff @(posedge clk) begin
    if (sel_b) mem[MonAReg] <= jdo[34:3];
    else if (cpu_wr) mem[avs_address] <= avs_writedata;
    if (issue_j) rd_q <= mem[pend_addr];
    else if (issue_c) rd_q <= mem[avs_address];
    rd_q2 <= rd_q;
  end

endmodule

// File: tb/tb_alarm_clk_debug_ocimem_seq.sv
// Scoreboard bench for the debug monitor RAM sequencer: expected read data is queued
// from a word-array model when a read is requested and popped when the DUT delivers.
module tb_alarm_clk_debug_ocimem_seq;
  localparam int ADDR_W = 8;
  localparam int LAT    = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        jtag_rd_done;

  always #5 clk = ~clk;

  alarm_clk_debug_ocimem_seq #(.ADDR_W(ADDR_W), .RAM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg), .MonAReg(MonAReg),
    .jtag_rd_done(jtag_rd_done)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [256];
  logic [7:0]  model_addr = '0;
  logic [31:0] jq[$];
  logic [31:0] cq[$];
  time         t_jdone = 0;
  time         t_cdone = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents JTAG or CPU read data.
  always @(negedge clk) begin
    if (reset_n && jtag_rd_done) begin
      t_jdone = $time;
      if (jq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_rd_done: got pulse expected none at %0t", $time);
      end else checkOutput("MonDReg", MonDReg, jq.pop_front());
    end
    if (reset_n && avs_read && !avs_waitrequest) begin
      t_cdone = $time;
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_cpu_rd: got completion expected none at %0t", $time);
      end else checkOutput("avs_readdata", avs_readdata, cq.pop_front());
    end
  end

  function automatic logic [37:0] mkA(input logic [7:0] a, input logic rd);
    logic [37:0] d;
    d = {6'($urandom), 32'($urandom)};
    d[24:17] = a;
    d[26] = rd;
    return d;
  endfunction

  function automatic logic [37:0] mkB(input logic [31:0] data);
    logic [37:0] d;
    d = {6'($urandom), 32'($urandom)};
    d[34:3] = data;
    return d;
  endfunction

  // All drive tasks start and end at posedge+1 so strobes can be issued back to back.
  // kind: 0 = take_action_ocimem_a, 1 = take_no_action_ocimem_a, 2 = take_action_ocimem_b
  task automatic jtagOp(input int kind, input logic [37:0] d);
    jdo = d;
    case (kind)
      0: begin
        take_action_ocimem_a = 1'b1;
        model_addr = d[24:17];
        if (d[26]) jq.push_back(model_mem[model_addr]);
      end
      1: begin
        take_no_action_ocimem_a = 1'b1;
        jq.push_back(model_mem[model_addr]);
        model_addr = model_addr + 8'd1;
      end
      default: begin
        take_action_ocimem_b = 1'b1;
        model_mem[model_addr] = d[34:3];
        model_addr = model_addr + 8'd1;
      end
    endcase
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic waitRd(output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (jtag_rd_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL rd_done_timeout: got no pulse expected pulse within 40 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [31:0] data, output int stalls);
    avs_address = a; avs_writedata = data; avs_write = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      stalls++;
      if (stalls >= 50) break;
    end
    if (stalls >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL cpu_wr_timeout: got waitrequest=1 expected release within 50 cycles");
    end
    @(posedge clk);
    if (stalls < 50) model_mem[a] = data;
    #1 avs_write = 1'b0;
  endtask

  task automatic cpuRead(input logic [7:0] a, output int stalls);
    avs_address = a; avs_read = 1'b1;
    cq.push_back(model_mem[a]);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      stalls++;
      if (stalls >= 50) break;
    end
    if (stalls >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL cpu_rd_timeout: got waitrequest=1 expected release within 50 cycles");
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic applyStimulus();
    int          st, n;
    logic [7:0]  a;
    logic        rd;
    a = 8'($urandom);
    case ($urandom_range(0, 4))
      0: cpuWrite(a, $urandom, st);
      1: cpuRead(a, st);
      2: begin
        jtagOp(2, mkB($urandom));
        checkOutput("rnd_MonAReg_b", 32'(MonAReg), 32'(model_addr));
      end
      3: begin
        rd = 1'($urandom);
        jtagOp(0, mkA(a, rd));
        if (rd) waitRd(n);
        checkOutput("rnd_MonAReg_a", 32'(MonAReg), 32'(model_addr));
      end
      default: begin
        jtagOp(1, 38'($urandom));
        waitRd(n);
        checkOutput("rnd_MonAReg_n", 32'(MonAReg), 32'(model_addr));
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, st2, n, total;

    #2;
    checkOutput("rst_MonDReg", MonDReg, 32'd0);
    checkOutput("rst_MonAReg", 32'(MonAReg), 32'd0);
    checkOutput("rst_readdata", avs_readdata, 32'd0);
    checkOutput("rst_waitreq", 32'(avs_waitrequest), 32'd1);
    checkOutput("rst_rd_done", 32'(jtag_rd_done), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_waitreq", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1;

    total = 0;
    for (int i = 0; i < 256; i++) begin
      cpuWrite(8'(i), $urandom, st);
      total += st;
    end
    checkOutput("fill_stalls", 32'(total), 32'd0);

    // Address load without read
    jtagOp(0, mkA(8'h3C, 1'b0));
    @(negedge clk);
    checkOutput("load_MonAReg", 32'(MonAReg), 32'h3C);
    checkOutput("load_waitreq", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1;

    // Write burst across the top of the address space, then read back
    jtagOp(0, mkA(8'hFE, 1'b0));
    jtagOp(2, mkB(32'hDEADBEEF));
    jtagOp(2, mkB(32'h12345678));
    checkOutput("wrap_MonAReg", 32'(MonAReg), 32'd0);
    jtagOp(0, mkA(8'hFE, 1'b1));
    waitRd(n);
    // strobe sampled, then 1+RAM_LAT edges, observed on the following low phase
    checkOutput("jrd_latency", 32'(n), 32'(2 + LAT));
    checkOutput("readback_fe", MonDReg, 32'hDEADBEEF);
    jtagOp(1, 38'($urandom));
    waitRd(n);
    checkOutput("burst_MonAReg1", 32'(MonAReg), 32'hFF);
    jtagOp(1, 38'($urandom));
    waitRd(n);
    checkOutput("burst_MonDReg", MonDReg, 32'h12345678);
    checkOutput("burst_MonAReg2", 32'(MonAReg), 32'd0);

    // CPU read and JTAG read start together: JTAG wins
    cpuWrite(8'd5, 32'hA5A5A5A5, st);
    fork
      cpuRead(8'd5, st);
      jtagOp(0, mkA(8'd7, 1'b1));
    join
    checkOutput("contend_stalls", 32'(st), 32'(3 + 2 * LAT));
    checkOutput("contend_order", 32'(t_jdone < t_cdone), 32'd1);
    checkOutput("contend_gap", 32'(t_cdone - t_jdone), 32'd20);

    // CPU write then JTAG read of the same word
    cpuWrite(8'd9, 32'h0BADF00D, st);
    checkOutput("cpu_wr_stalls", 32'(st), 32'd0);
    jtagOp(0, mkA(8'd9, 1'b1));
    waitRd(n);
    checkOutput("cpu_then_jtag", MonDReg, 32'h0BADF00D);

    // Same-address CPU and JTAG writes
    jtagOp(0, mkA(8'd3, 1'b0));
    fork
      cpuWrite(8'd3, 32'hC0C0C0C0, st2);
      begin
        jtagOp(2, mkB(32'h5A5A0003));
        jtagOp(0, mkA(8'd3, 1'b1));
        waitRd(n);
      end
    join
    checkOutput("same_addr_jtag", MonDReg, 32'h5A5A0003);
    checkOutput("same_addr_stalls", 32'(st2), 32'(3 + LAT));
    jtagOp(0, mkA(8'd3, 1'b1));
    waitRd(n);
    checkOutput("same_addr_final", MonDReg, 32'hC0C0C0C0);

    // Asynchronous reset while a JTAG read is in flight
    jtagOp(0, mkA(8'd9, 1'b1));
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_MonDReg", MonDReg, 32'd0);
    checkOutput("arst_MonAReg", 32'(MonAReg), 32'd0);
    checkOutput("arst_waitreq", 32'(avs_waitrequest), 32'd1);
    checkOutput("arst_rd_done", 32'(jtag_rd_done), 32'd0);
    jq.delete();
    model_addr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("arst_recover_waitreq", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) applyStimulus();

    repeat (5) @(negedge clk);
    checkOutput("jq_drained", 32'(jq.size()), 32'd0);
    checkOutput("cq_drained", 32'(cq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
